fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/arm_pkg.sv | 28 ++
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/fetch_unit.sv | 136 +++++++++++++
 tb/tb_fetch_unit.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared types and constants for the instruction fetch path: reset address,
// word size, fetch state encoding and the buffered {pc, instr} entry.
package arm_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam int          WORD_BYTES       = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      FLUSH
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   // Sequential fetch address; 32-bit arithmetic wraps FFFF_FFFC -> 0 naturally.
   function automatic logic [31:0] next_pc(input logic [31:0] pc);
      return pc + 32'(WORD_BYTES);
   endfunction

   function automatic logic [31:0] align_pc(input logic [31:0] addr);
      return addr & ~(32'(WORD_BYTES) - 32'd1);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer holding {pc, instr} pairs between the memory port
// and the decoder. Head entry is read straight out of the storage registers.
module fetch_fifo
   import arm_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  fetch_entry_t             wr_data,
   output fetch_entry_t             rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == DEPTH_C);
   assign do_pop  = pop && !empty;
   // A full buffer still accepts a write when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign rd_data = mem[rd_ptr];

   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         // NOTE: storage is reset because the head entry drives instr_out
         // directly, and that output must read zero out of reset.
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one outstanding word read at a time, buffers
// returned words for the decoder, and handles redirects from the PC path.
module fetch_unit
   import arm_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr_out,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        pc_load,
   input  logic [31:0] pc_target
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   fetch_state_t  state;
   logic [31:0]   fetch_pc;
   logic [CW-1:0] fifo_count;
   logic [CW-1:0] count_after;
   logic          fifo_full;
   logic          fifo_empty;
   logic          ack_live;
   logic          push;
   logic          pop;
   logic          slot_free;
   fetch_entry_t  wr_entry;
   fetch_entry_t  head;

   assign ack_live = (state == WAIT) && imem_ack;
   assign pop      = instr_valid && instr_ready;
   assign push     = ack_live && !pc_load && (!fifo_full || pop);
   assign wr_entry = '{pc: fetch_pc, instr: imem_rdata};

   // Occupancy once this cycle's push/pop/flush land; a new request is only
   // issued when that leaves room for the word it will bring back.
   // NOTE: every always_comb output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      count_after = fifo_count;
      if (pc_load) begin
         count_after = '0;
      end else begin
         count_after = fifo_count + CW'(push) - CW'(pop);
      end
   end

   assign slot_free = (count_after < DEPTH_C);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
         imem_req <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pc_load) begin
                  fetch_pc <= align_pc(pc_target);
                  state    <= WAIT;
                  imem_req <= 1'b1;
               end else if (slot_free) begin
                  state    <= WAIT;
                  imem_req <= 1'b1;
               end
            end
            WAIT: begin
               if (pc_load) begin
                  fetch_pc <= align_pc(pc_target);
                  if (imem_ack) begin
                     // The old request completed this cycle, so the target
                     // can be requested immediately; its data is dropped.
                     state    <= WAIT;
                     imem_req <= 1'b1;
                  end else begin
                     state    <= FLUSH;
                     imem_req <= 1'b0;
                  end
               end else if (imem_ack) begin
                  fetch_pc <= next_pc(fetch_pc);
                  if (slot_free) begin
                     state    <= WAIT;
                     imem_req <= 1'b1;
                  end else begin
                     state    <= IDLE;
                     imem_req <= 1'b0;
                  end
               end
            end
            FLUSH: begin
               if (pc_load) begin
                  fetch_pc <= align_pc(pc_target);
               end
               if (imem_ack) begin
                  state    <= WAIT;
                  imem_req <= 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               imem_req <= 1'b0;
            end
         endcase
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push),
      .pop     (pop),
      .flush   (pc_load),
      .wr_data (wr_entry),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign imem_addr   = fetch_pc;
   assign instr_valid = !fifo_empty;
   assign instr_out   = head.instr;
   assign instr_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus pushes expected {pc, instr} pairs,
// an independent monitor pops and compares on every decoder handshake.
module tb_fetch_unit;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr_out;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        pc_load;
   logic [31:0] pc_target;

   int   total = 0;
   int   bad   = 0;
   bit   auto_ack;
   exp_t exp_q[$];

   logic        prev_stall;
   logic [31:0] prev_out;
   logic [31:0] prev_pc;

   fetch_unit #(
      .RESET_PC (32'h0000_0000),
      .DEPTH    (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr_out   (instr_out),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .pc_load     (pc_load),
      .pc_target   (pc_target)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive_mem();
      if (auto_ack && imem_req) begin
         imem_ack   = 1'b1;
         imem_rdata = mem_word(imem_addr);
      end else begin
         imem_ack   = 1'b0;
         imem_rdata = 32'hDEAD_DEAD;
      end
   endtask

   // Inputs change 2 time units after each rising edge.
   task automatic tick();
      @(posedge clk);
      #2;
      drive_mem();
   endtask

   task automatic expect_word(input logic [31:0] pc, input logic [31:0] instr);
      exp_q.push_back('{pc: pc, instr: instr});
   endtask

   task automatic do_reset();
      check("sb_drain", 32'(exp_q.size()), 32'd0);
      rst_n       = 1'b0;
      pc_load     = 1'b0;
      pc_target   = 32'h0;
      auto_ack    = 1'b0;
      imem_ack    = 1'b0;
      instr_ready = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Scoreboard monitor and hold-stable check, sampled on the falling edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && instr_valid) begin
            check("hold_instr", instr_out, prev_out);
            check("hold_pc", instr_pc, prev_pc);
         end
         if (instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL sb_underflow: got instr_pc %h expected no word", instr_pc);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("pop_pc", instr_pc, e.pc);
               check("pop_instr", instr_out, e.instr);
            end
         end
         prev_stall = instr_valid && !instr_ready;
         prev_out   = instr_out;
         prev_pc    = instr_pc;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n       = 1'b0;
      pc_load     = 1'b0;
      pc_target   = 32'h0;
      imem_ack    = 1'b0;
      imem_rdata  = 32'h0;
      instr_ready = 1'b1;
      auto_ack    = 1'b1;
      prev_stall  = 1'b0;

      // Reset values, first request, streaming at one word per cycle.
      tick();
      check("rst_req", {31'd0, imem_req}, 32'd0);
      check("rst_addr", imem_addr, 32'h0000_0000);
      check("rst_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_instr", instr_out, 32'h0);
      check("rst_pc", instr_pc, 32'h0);
      tick();
      expect_word(32'h0000_0000, 32'h5A5A_0000);
      expect_word(32'h0000_0004, 32'h5A5A_0004);
      expect_word(32'h0000_0008, 32'h5A5A_0008);
      expect_word(32'h0000_000C, 32'h5A5A_000C);
      rst_n = 1'b1;
      tick();
      check("first_req", {31'd0, imem_req}, 32'd1);
      check("first_addr", imem_addr, 32'h0000_0000);
      check("first_valid", {31'd0, instr_valid}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("stream_valid", {31'd0, instr_valid}, 32'd1);
      end
      tick();
      instr_ready = 1'b0;

      // Decoder stalled for 6 cycles: two words held, no further requests.
      for (int i = 0; i < 6; i++) begin
         tick();
         check("stall_req", {31'd0, imem_req}, 32'd0);
         check("stall_pc", instr_pc, 32'h0000_0010);
         check("stall_instr", instr_out, 32'h5A5A_0010);
      end
      expect_word(32'h0000_0010, 32'h5A5A_0010);
      expect_word(32'h0000_0014, 32'h5A5A_0014);
      instr_ready = 1'b1;
      tick();
      check("drain_pc", instr_pc, 32'h0000_0014);
      tick();
      instr_ready = 1'b0;

      // Redirect while waiting; the late ack is dropped.
      do_reset();
      tick();
      pc_load   = 1'b1;
      pc_target = 32'h0000_0103;
      tick();
      pc_load = 1'b0;
      check("flush_req", {31'd0, imem_req}, 32'd0);
      check("flush_valid", {31'd0, instr_valid}, 32'd0);
      tick();
      tick();
      imem_ack   = 1'b1;
      imem_rdata = 32'h1111_2222;
      tick();
      check("redir_req", {31'd0, imem_req}, 32'd1);
      check("redir_addr", imem_addr, 32'h0000_0100);
      check("redir_valid", {31'd0, instr_valid}, 32'd0);
      auto_ack = 1'b1;
      drive_mem();
      expect_word(32'h0000_0100, 32'h5A5A_0100);
      tick();
      check("redir_pc", instr_pc, 32'h0000_0100);
      tick();
      instr_ready = 1'b0;

      // Redirect together with an ack and a pop.
      do_reset();
      auto_ack = 1'b1;
      drive_mem();
      expect_word(32'h0000_0000, 32'h5A5A_0000);
      expect_word(32'h0000_0004, 32'h5A5A_0004);
      expect_word(32'h0000_0200, 32'h5A5A_0200);
      tick();
      tick();
      tick();
      pc_load   = 1'b1;
      pc_target = 32'h0000_0200;
      tick();
      pc_load = 1'b0;
      check("coinc_valid", {31'd0, instr_valid}, 32'd0);
      check("coinc_addr", imem_addr, 32'h0000_0200);
      check("coinc_req", {31'd0, imem_req}, 32'd1);
      tick();
      check("coinc_pc", instr_pc, 32'h0000_0200);
      tick();
      instr_ready = 1'b0;

      // Address wrap at the top of the address space, unaligned target.
      do_reset();
      tick();
      pc_load    = 1'b1;
      pc_target  = 32'hFFFF_FFFF;
      imem_ack   = 1'b1;
      imem_rdata = 32'h3333_4444;
      tick();
      pc_load = 1'b0;
      check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
      check("wrap_valid0", {31'd0, instr_valid}, 32'd0);
      auto_ack = 1'b1;
      drive_mem();
      expect_word(32'hFFFF_FFFC, 32'hA5A5_FFFC);
      tick();
      check("wrap_addr1", imem_addr, 32'h0000_0000);
      check("wrap_pc", instr_pc, 32'hFFFF_FFFC);
      tick();
      instr_ready = 1'b0;
      check("wrap_next_pc", instr_pc, 32'h0000_0000);
      check("wrap_next_instr", instr_out, 32'h5A5A_0000);

      // Repeated redirects during FLUSH: latest target, one ack dropped.
      do_reset();
      tick();
      pc_load   = 1'b1;
      pc_target = 32'h0000_0300;
      tick();
      pc_target = 32'h0000_040A;
      tick();
      pc_load = 1'b0;
      check("reflush_req", {31'd0, imem_req}, 32'd0);
      imem_ack   = 1'b1;
      imem_rdata = 32'h5555_6666;
      tick();
      check("reflush_addr", imem_addr, 32'h0000_0408);
      check("reflush_valid", {31'd0, instr_valid}, 32'd0);
      auto_ack = 1'b1;
      drive_mem();
      expect_word(32'h0000_0408, 32'h5A5A_0408);
      tick();
      tick();
      instr_ready = 1'b0;

      // Reset mid-request; a stray ack right after release is ignored.
      do_reset();
      tick();
      rst_n = 1'b0;
      #1;
      check("midrst_req", {31'd0, imem_req}, 32'd0);
      check("midrst_addr", imem_addr, 32'h0000_0000);
      tick();
      rst_n      = 1'b1;
      imem_ack   = 1'b1;
      imem_rdata = 32'h7777_8888;
      auto_ack   = 1'b1;
      expect_word(32'h0000_0000, 32'h5A5A_0000);
      tick();
      check("late_ack_valid", {31'd0, instr_valid}, 32'd0);
      check("late_ack_req", {31'd0, imem_req}, 32'd1);
      tick();
      check("restart_pc", instr_pc, 32'h0000_0000);
      check("restart_instr", instr_out, 32'h5A5A_0000);
      tick();
      instr_ready = 1'b0;
      tick();
      check("sb_drain", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
